// File: rtl/posix_watches_pkg.sv
// Shared constants, types and FSM states for the multi-zone POSIX watches.
package posix_watches_pkg;

   localparam int SEC_PER_DAY   = 86400;
   localparam int SEC_PER_HOUR  = 3600;
   localparam int SEC_PER_MIN   = 60;
   localparam int DOW_SHIFT_SEC = 604800;   // one week: keeps day-of-week intact
   localparam int OFFSET_MIN_LO = -720;
   localparam int OFFSET_MIN_HI = 840;

   typedef logic        [4:0]  hour_t;
   typedef logic        [5:0]  min_t;
   typedef logic        [5:0]  sec_t;
   typedef logic        [2:0]  dow_t;
   typedef logic signed [10:0] offset_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_DIV,
      ST_SPLIT,
      ST_COMMIT
   } state_t;

   // True when a zone offset lies inside the supported UTC-12h..UTC+14h range.
   function automatic logic offset_ok(input offset_t off);
      return (int'(off) >= OFFSET_MIN_LO) && (int'(off) <= OFFSET_MIN_HI);
   endfunction

endpackage

// File: rtl/posix_div_seq.sv
// Restoring divider, one quotient bit per cycle. A start pulse captures the
// operands; done is high during the final iteration, so quotient/remainder
// are valid from the following cycle. Only the low STEPS dividend bits are
// divided (the upper bits are known to be zero by the caller).
module posix_div_seq #(
   parameter int DIVIDEND_W = 34,
   parameter int DIVISOR_W  = 17,
   parameter int STEPS      = 33
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [DIVIDEND_W-1:0] dividend,
   input  logic [DIVISOR_W-1:0]  divisor,
   output logic                  done,
   output logic [DIVIDEND_W-1:0] quotient,
   output logic [DIVISOR_W-1:0]  remainder
);

   localparam int CNT_W = $clog2(STEPS + 1);

   logic [STEPS-1:0]     quo;
   logic [DIVISOR_W-1:0] rem;
   logic [DIVISOR_W-1:0] dsr;
   logic [CNT_W-1:0]     cnt;
   logic [DIVISOR_W:0]   trial;
   logic                 fits;
   logic                 unused_dividend_hi;

   assign unused_dividend_hi = ^dividend[DIVIDEND_W-1:STEPS];

   // Trial subtraction for the current step: shift in the next dividend bit.
   always_comb begin
      trial = {rem, quo[STEPS-1]};
      fits  = (trial >= {1'b0, dsr});
   end

   // Iteration register: load on start, then one restoring step per cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         quo <= '0;
         rem <= '0;
         dsr <= '0;
         cnt <= '0;
      end else if (start) begin
         quo <= dividend[STEPS-1:0];
         rem <= '0;
         dsr <= divisor;
         cnt <= CNT_W'(STEPS);
      end else if (cnt != '0) begin
         cnt <= cnt - 1'b1;
         if (fits) begin
            rem <= DIVISOR_W'(trial - {1'b0, dsr});
            quo <= {quo[STEPS-2:0], 1'b1};
         end else begin
            rem <= trial[DIVISOR_W-1:0];
            quo <= {quo[STEPS-2:0], 1'b0};
         end
      end
   end

   assign done      = (cnt == CNT_W'(1));
   assign quotient  = DIVIDEND_W'(quo);
   assign remainder = rem;

endmodule

// File: rtl/posix_time_watches_mz.sv
// Multi-zone POSIX watches: free-running seconds counter with prescaler and
// per-zone hour/min/sec conversion through one shared sequential divider.
// Optional macro POSIX_WATCHES_DOW_EN adds a per-zone day-of-week output.
module posix_time_watches_mz
   import posix_watches_pkg::*;
#(
   parameter int          CLK_FREQ_HZ        = 25_000_000,
   parameter int          ZONES              = 2,
   parameter logic [31:0] START_POSIX_TIME   = 32'd0,
   parameter int          DEFAULT_OFFSET_MIN = 180
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic [31:0]        user_posix_time_i,
   input  logic               user_posix_time_en_i,
   input  logic               offset_we_i,
   input  logic [2:0]         offset_zone_i,
   input  logic [10:0]        offset_min_i,
   output logic [31:0]        posix_time_o,
   output logic               last_tick_o,
   output logic               sec_blnk_o,
   output logic [ZONES*5-1:0] hour_o,
   output logic [ZONES*6-1:0] min_o,
   output logic [ZONES*6-1:0] sec_o,
   output logic               upd_o,
   output logic               busy_o
`ifdef POSIX_WATCHES_DOW_EN
   ,
   output logic [ZONES*3-1:0] dow_o
`endif
);

   localparam int ZW = (ZONES > 1) ? $clog2(ZONES) : 1;
   localparam int NZ = 1 << ZW;
   localparam int PW = $clog2(CLK_FREQ_HZ);

   if (ZONES < 1 || ZONES > 8 || CLK_FREQ_HZ < ZONES * 35 + 2) begin : g_bad_params
      $error("posix_time_watches_mz: ZONES must be 1..8 and CLK_FREQ_HZ >= ZONES*35+2");
   end

   logic [PW-1:0]      presc;
   logic               tick;
   logic               wr_ok;
   logic               pending;
   offset_t            offsets [NZ];
   state_t             state, state_n;
   logic [31:0]        snap;
   logic [ZW-1:0]      zone;
   logic               last_zone;
   logic signed [33:0] local_sec;
   logic               div_done;
   logic [33:0]        div_quo;
   logic [16:0]        div_rem;
   hour_t              hour_c;
   min_t               min_c;
   sec_t               sec_c;
   hour_t              sh_hour [NZ];
   min_t               sh_min  [NZ];
   sec_t               sh_sec  [NZ];

   // A load owns the cycle, so a coincident prescaler wrap is dropped.
   assign tick  = !user_posix_time_en_i && (presc == PW'(CLK_FREQ_HZ - 1));
   assign wr_ok = offset_we_i && (int'(offset_zone_i) < ZONES)
                  && offset_ok($signed(offset_min_i));

   // Seconds counter with prescaler, tick pulse and blink toggle.
   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         presc        <= '0;
         posix_time_o <= START_POSIX_TIME;
         last_tick_o  <= 1'b0;
         sec_blnk_o   <= 1'b0;
      end else begin
         last_tick_o <= tick;
         if (user_posix_time_en_i) begin
            posix_time_o <= user_posix_time_i;
            presc        <= '0;
         end else if (tick) begin
            presc        <= '0;
            posix_time_o <= posix_time_o + 32'd1;
            sec_blnk_o   <= ~sec_blnk_o;
         end else begin
            presc <= presc + 1'b1;
         end
      end
   end

   // Per-zone offset register file; out-of-range writes are dropped.
   // NOTE: this small register file is reset explicitly because every zone must start at the default offset.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int z = 0; z < NZ; z++) offsets[z] <= offset_t'(DEFAULT_OFFSET_MIN);
      end else if (wr_ok) begin
         offsets[offset_zone_i[ZW-1:0]] <= $signed(offset_min_i);
      end
   end

   // Pending flag: set by any time-changing event, consumed when a pass starts.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) pending <= 1'b1;
      else       pending <= (pending && state != ST_IDLE) || user_posix_time_en_i
                            || wr_ok || tick;
   end

   // FSM state register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state <= ST_IDLE;
      else       state <= state_n;
   end

   // FSM next-state logic.
   // NOTE: state_n is defaulted before the case so no path leaves it unassigned (no latch).
   always_comb begin
      state_n = state;
      unique case (state)
         ST_IDLE:   if (pending) state_n = ST_LOAD;
         ST_LOAD:   state_n = ST_DIV;
         ST_DIV:    if (div_done) state_n = ST_SPLIT;
         ST_SPLIT:  state_n = last_zone ? ST_COMMIT : ST_LOAD;
         ST_COMMIT: state_n = ST_IDLE;
         default:   state_n = ST_IDLE;
      endcase
   end

   assign busy_o    = (state != ST_IDLE);
   assign last_zone = (zone == ZW'(ZONES - 1));

   // Snapshot of the counter and zone index for the running pass.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         snap <= '0;
         zone <= '0;
      end else if (state == ST_IDLE && pending) begin
         snap <= posix_time_o;
         zone <= '0;
      end else if (state == ST_SPLIT && !last_zone) begin
         zone <= zone + 1'b1;
      end
   end

   // Local seconds for the current zone, shifted by a week when negative.
   always_comb begin
      local_sec = $signed({2'b00, snap})
                + $signed({{23{offsets[zone][10]}}, offsets[zone]}) * 34'sd60;
      if (local_sec < 0) local_sec = local_sec + 34'(DOW_SHIFT_SEC);
   end

   posix_div_seq #(
      .DIVIDEND_W (34),
      .DIVISOR_W  (17),
      .STEPS      (33)
   ) u_div (
      .clk       (clk_i),
      .rst       (rst_i),
      .start     (state == ST_LOAD),
      .dividend  (local_sec),
      .divisor   (17'(SEC_PER_DAY)),
      .done      (div_done),
      .quotient  (div_quo),
      .remainder (div_rem)
   );

   // Split seconds-of-day into hour, minute and second.
   always_comb begin
      hour_c = hour_t'(div_rem / 17'(SEC_PER_HOUR));
      min_c  = min_t'((div_rem % 17'(SEC_PER_HOUR)) / 17'(SEC_PER_MIN));
      sec_c  = sec_t'(div_rem % 17'(SEC_PER_MIN));
   end

   // Shadow registers collect each zone's result during the pass.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int z = 0; z < NZ; z++) begin
            sh_hour[z] <= '0;
            sh_min[z]  <= '0;
            sh_sec[z]  <= '0;
         end
      end else if (state == ST_SPLIT) begin
         sh_hour[zone] <= hour_c;
         sh_min[zone]  <= min_c;
         sh_sec[zone]  <= sec_c;
      end
   end

   // Commit all zones at once so partial updates are never visible.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         hour_o <= '0;
         min_o  <= '0;
         sec_o  <= '0;
         upd_o  <= 1'b0;
      end else begin
         upd_o <= (state == ST_COMMIT);
         if (state == ST_COMMIT) begin
            for (int z = 0; z < ZONES; z++) begin
               hour_o[z*5 +: 5] <= sh_hour[z];
               min_o[z*6 +: 6]  <= sh_min[z];
               sec_o[z*6 +: 6]  <= sh_sec[z];
            end
         end
      end
   end

`ifdef POSIX_WATCHES_DOW_EN
   dow_t sh_dow [NZ];
   dow_t dow_c;

   // 1970-01-01 was a Thursday, hence the +4.
   assign dow_c = dow_t'((div_quo + 34'd4) % 34'd7);

   // Day-of-week shadow and committed output.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int z = 0; z < NZ; z++) sh_dow[z] <= '0;
         dow_o <= '0;
      end else begin
         if (state == ST_SPLIT) sh_dow[zone] <= dow_c;
         if (state == ST_COMMIT) begin
            for (int z = 0; z < ZONES; z++) dow_o[z*3 +: 3] <= sh_dow[z];
         end
      end
   end
`else
   logic unused_days;
   assign unused_days = ^div_quo;
`endif

endmodule

// File: tb/tb_posix_time_watches_mz.sv
// Directed bench for posix_time_watches_mz (CLK_FREQ_HZ=100, ZONES=2).
// Build with POSIX_WATCHES_DOW_EN to also check the day-of-week output.
module tb_posix_time_watches_mz;

   localparam int CLK_HZ = 100;
   localparam int NZ     = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic [31:0]   user_posix;
   logic          user_en;
   logic          off_we;
   logic [2:0]    off_zone;
   logic [10:0]   off_min;
   logic [31:0]   posix;
   logic          last_tick;
   logic          blnk;
   logic [NZ*5-1:0] hour;
   logic [NZ*6-1:0] mins;
   logic [NZ*6-1:0] secs;
   logic          upd;
   logic          busy;
`ifdef POSIX_WATCHES_DOW_EN
   logic [NZ*3-1:0] dow;
`endif

   int tests = 0;
   int fails = 0;
   int cyc;

   posix_time_watches_mz #(
      .CLK_FREQ_HZ        (CLK_HZ),
      .ZONES              (NZ),
      .START_POSIX_TIME   (32'd0),
      .DEFAULT_OFFSET_MIN (180)
   ) dut (
      .clk_i                (clk),
      .rst_i                (rst),
      .user_posix_time_i    (user_posix),
      .user_posix_time_en_i (user_en),
      .offset_we_i          (off_we),
      .offset_zone_i        (off_zone),
      .offset_min_i         (off_min),
      .posix_time_o         (posix),
      .last_tick_o          (last_tick),
      .sec_blnk_o           (blnk),
      .hour_o               (hour),
      .min_o                (mins),
      .sec_o                (secs),
      .upd_o                (upd),
      .busy_o               (busy)
`ifdef POSIX_WATCHES_DOW_EN
      ,
      .dow_o                (dow)
`endif
   );

   always #5 clk = ~clk;

   // Edges since reset release; sampled on the falling edge it equals the
   // number of the rising edge that produced the current outputs.
   always @(posedge clk or posedge rst) begin
      if (rst) cyc <= 0;
      else     cyc <= cyc + 1;
   end

   function automatic logic [33:0] tv(input int h0, m0, s0, h1, m1, s1);
      return {5'(h1), 5'(h0), 6'(m1), 6'(m0), 6'(s1), 6'(s0)};
   endfunction

   task automatic wait_upd(output int at);
      at = -1;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (upd) begin
            at = cyc;
            break;
         end
      end
      if (at < 0) begin
         tests++;
         fails++;
         $display("FAIL upd_timeout: no upd_o within 400 cycles (cyc=%0d)", cyc);
      end
   endtask

   task automatic wait_cyc(input int n);
      for (int i = 0; i < 1000 && cyc < n; i++) @(negedge clk);
   endtask

   // Reset, then load v at edge 1, write zone0 at edge 1 and zone1 at edge 2.
   task automatic restart(input logic [31:0] v, input int o0, input int o1);
      rst = 1'b1;
      user_en = 1'b0;
      off_we = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      user_posix = v;
      user_en = 1'b1;
      off_we = 1'b1;
      off_zone = 3'd0;
      off_min = 11'(o0);
      @(negedge clk);
      user_en = 1'b0;
      off_zone = 3'd1;
      off_min = 11'(o1);
      @(negedge clk);
      off_we = 1'b0;
   endtask

   task automatic test_reset();
      int at;
      rst = 1'b1;
      user_posix = '0;
      user_en = 1'b0;
      off_we = 1'b0;
      off_zone = '0;
      off_min = '0;
      repeat (3) @(negedge clk);
      tests++;
      if ({hour, mins, secs} !== 34'd0 || posix !== 32'd0) begin
         fails++;
         $display("FAIL reset_values: time=%h posix=%0d, want 0/0", {hour, mins, secs}, posix);
      end
      tests++;
      if ({busy, upd, blnk, last_tick} !== 4'b0000) begin
         fails++;
         $display("FAIL reset_flags: busy/upd/blnk/tick=%b, want 0000", {busy, upd, blnk, last_tick});
      end
      rst = 1'b0;
      off_we = 1'b1;
      off_zone = 3'd1;
      off_min = 11'd0;
      @(negedge clk);
      off_we = 1'b0;
      tests++;
      if (busy !== 1'b1) begin
         fails++;
         $display("FAIL start_after_reset: busy=%b, want 1", busy);
      end
      wait_upd(at);
      tests++;
      if (at !== 72) begin
         fails++;
         $display("FAIL first_upd_latency: at cycle %0d, want 72", at);
      end
      tests++;
      if ({hour, mins, secs} !== tv(3, 0, 0, 0, 0, 0)) begin
         fails++;
         $display("FAIL first_time: got %h want %h", {hour, mins, secs}, tv(3, 0, 0, 0, 0, 0));
      end
      tests++;
      if (busy !== 1'b0) begin
         fails++;
         $display("FAIL idle_after_commit: busy=%b, want 0", busy);
      end
`ifdef POSIX_WATCHES_DOW_EN
      tests++;
      if (dow !== {3'd4, 3'd4}) begin
         fails++;
         $display("FAIL first_dow: got %b want %b", dow, {3'd4, 3'd4});
      end
`endif
   endtask

   task automatic test_neg_offset();
      int at;
      restart(32'd0, 180, -300);
      wait_upd(at);
      wait_upd(at);
      tests++;
      if (at !== 144 || {hour, mins, secs} !== tv(3, 0, 0, 19, 0, 0)) begin
         fails++;
         $display("FAIL neg_offset: at %0d time %h, want 144 %h", at, {hour, mins, secs},
                  tv(3, 0, 0, 19, 0, 0));
      end
`ifdef POSIX_WATCHES_DOW_EN
      tests++;
      if (dow !== {3'd3, 3'd4}) begin
         fails++;
         $display("FAIL neg_offset_dow: got %b want %b", dow, {3'd3, 3'd4});
      end
`endif
   endtask

   task automatic test_epoch();
      int at;
      restart(32'd1700000000, 0, 180);
      wait_upd(at);
      wait_upd(at);
      tests++;
      if ({hour, mins, secs} !== tv(22, 13, 20, 1, 13, 20)) begin
         fails++;
         $display("FAIL epoch_1700000000: got %h want %h", {hour, mins, secs},
                  tv(22, 13, 20, 1, 13, 20));
      end
`ifdef POSIX_WATCHES_DOW_EN
      tests++;
      if (dow !== {3'd3, 3'd2}) begin
         fails++;
         $display("FAIL epoch_dow: got %b want %b", dow, {3'd3, 3'd2});
      end
`endif
   endtask

   task automatic test_day_rollover();
      int at;
      restart(32'd86399, 0, 0);
      wait_upd(at);
      wait_cyc(100);
      tests++;
      if (last_tick !== 1'b0 || posix !== 32'd86399) begin
         fails++;
         $display("FAIL pre_tick: tick=%b posix=%0d, want 0/86399", last_tick, posix);
      end
      @(negedge clk);
      tests++;
      if (last_tick !== 1'b1 || posix !== 32'd86400 || blnk !== 1'b1) begin
         fails++;
         $display("FAIL tick: tick=%b posix=%0d blnk=%b, want 1/86400/1", last_tick, posix, blnk);
      end
      wait_upd(at);
      tests++;
      if (at !== 144 || {hour, mins, secs} !== tv(23, 59, 59, 23, 59, 59)) begin
         fails++;
         $display("FAIL before_midnight: at %0d time %h, want 144 %h", at, {hour, mins, secs},
                  tv(23, 59, 59, 23, 59, 59));
      end
      wait_upd(at);
      tests++;
      if (at !== 216 || {hour, mins, secs} !== tv(0, 0, 0, 0, 0, 0)) begin
         fails++;
         $display("FAIL midnight: at %0d time %h, want 216 %h", at, {hour, mins, secs},
                  tv(0, 0, 0, 0, 0, 0));
      end
`ifdef POSIX_WATCHES_DOW_EN
      tests++;
      if (dow !== {3'd5, 3'd5}) begin
         fails++;
         $display("FAIL midnight_dow: got %b want %b", dow, {3'd5, 3'd5});
      end
`endif
   endtask

   task automatic test_back_to_back();
      int at;
      restart(32'd0, 180, 0);
      wait_upd(at);
      wait_upd(at);
      // Third pass starts at edge 145; zone0 divides over edges 147..179.
      wait_cyc(149);
      user_posix = 32'd1700000000;
      user_en = 1'b1;
      @(negedge clk);
      user_en = 1'b0;
      tests++;
      if (busy !== 1'b1) begin
         fails++;
         $display("FAIL busy_mid_pass: busy=%b, want 1", busy);
      end
      wait_cyc(154);
      off_we = 1'b1;
      off_zone = 3'd0;
      off_min = 11'd0;
      @(negedge clk);
      off_we = 1'b0;
      wait_upd(at);
      tests++;
      if (at !== 216 || {hour, mins, secs} !== tv(3, 0, 1, 0, 0, 1)) begin
         fails++;
         $display("FAIL old_snapshot: at %0d time %h, want 216 %h", at, {hour, mins, secs},
                  tv(3, 0, 1, 0, 0, 1));
      end
      wait_upd(at);
      tests++;
      if (at !== 288 || {hour, mins, secs} !== tv(22, 13, 20, 22, 13, 20)) begin
         fails++;
         $display("FAIL new_values: at %0d time %h, want 288 %h", at, {hour, mins, secs},
                  tv(22, 13, 20, 22, 13, 20));
      end
      tests++;
      if (busy !== 1'b0) begin
         fails++;
         $display("FAIL idle_after_extra_pass: busy=%b, want 0", busy);
      end
   endtask

   task automatic test_invalid_and_reset();
      int at;
      restart(32'd0, 180, 0);
      repeat (3) wait_upd(at);
      wait_upd(at);
      tests++;
      if (at !== 288 || {hour, mins, secs} !== tv(3, 0, 2, 0, 0, 2)) begin
         fails++;
         $display("FAIL pre_invalid: at %0d time %h, want 288 %h", at, {hour, mins, secs},
                  tv(3, 0, 2, 0, 0, 2));
      end
      off_we = 1'b1;
      off_zone = 3'd0;
      off_min = 11'd900;
      @(negedge clk);
      off_zone = 3'd5;
      off_min = 11'd60;
      @(negedge clk);
      off_we = 1'b0;
      wait_cyc(295);
      tests++;
      if (busy !== 1'b0) begin
         fails++;
         $display("FAIL invalid_write_pending: busy=%b at cycle %0d, want 0", busy, cyc);
      end
      wait_upd(at);
      tests++;
      if (at !== 373 || {hour, mins, secs} !== tv(3, 0, 3, 0, 0, 3)) begin
         fails++;
         $display("FAIL invalid_write_ignored: at %0d time %h, want 373 %h", at,
                  {hour, mins, secs}, tv(3, 0, 3, 0, 0, 3));
      end
      // Next pass starts at edge 402; edge 410 is inside zone0 division.
      wait_cyc(410);
      tests++;
      if (busy !== 1'b1) begin
         fails++;
         $display("FAIL busy_before_abort: busy=%b, want 1", busy);
      end
      rst = 1'b1;
      #1;
      tests++;
      if ({hour, mins, secs} !== 34'd0 || posix !== 32'd0 || {busy, upd, blnk, last_tick} !== 4'b0000) begin
         fails++;
         $display("FAIL mid_div_reset: time=%h posix=%0d flags=%b, want 0/0/0000",
                  {hour, mins, secs}, posix, {busy, upd, blnk, last_tick});
      end
`ifdef POSIX_WATCHES_DOW_EN
      tests++;
      if (dow !== '0) begin
         fails++;
         $display("FAIL mid_div_reset_dow: got %b want 0", dow);
      end
`endif
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      test_reset();
      test_neg_offset();
      test_epoch();
      test_day_rollover();
      test_back_to_back();
      test_invalid_and_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
